// File: rtl/pll_hdmi_cfg_master.sv
// Avalon-MM initiator that reprograms the HDMI PLL through its reconfig
// controller: latches a counter/fraction set, writes it in a fixed order,
// triggers reconfig, polls status and then waits for lock.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for cfg_start
// W_MODE  | write 0 to MODE (waitrequest mode)
// W_N     | write N counter
// W_M     | write M counter
// W_C0    | write C0 counter
// W_K     | write fractional K
// W_BW    | write bandwidth code
// W_CP    | write charge-pump code
// W_START | write 1 to START
// POLL    | read STATUS until bit0 set, one idle cycle between reads
// LOCK    | mask stale lock for 16 cycles, then wait for pll_locked
// ERR     | one-cycle error state after a timeout, then IDLE
module pll_hdmi_cfg_master #(
    parameter logic [19:0] TIMEOUT = 20'hFFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_start,
    input  logic [17:0] cfg_m,
    input  logic [17:0] cfg_n,
    input  logic [17:0] cfg_c0,
    input  logic [31:0] cfg_k,
    input  logic [3:0]  cfg_bw,
    input  logic [2:0]  cfg_cp,
    output logic        cfg_busy,
    output logic        cfg_done,
    output logic        cfg_error,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_write,
    output logic        mgmt_read,
    output logic [31:0] mgmt_writedata,
    input  logic [31:0] mgmt_readdata,
    input  logic        mgmt_waitrequest,
    input  logic        pll_locked
);

    typedef enum logic [3:0] {
        IDLE, W_MODE, W_N, W_M, W_C0, W_K, W_BW, W_CP, W_START, POLL, LOCK, ERR
    } state_t;

    state_t      state;
    state_t      wr_next;
    logic [5:0]  nxt_addr;
    logic [31:0] nxt_data;
    logic [17:0] m_q, n_q, c0_q;
    logic [31:0] k_q;
    logic [3:0]  bw_q;
    logic [2:0]  cp_q;
    logic [19:0] tcnt;
    logic [4:0]  mask_cnt;
    logic        poll_gap;
    logic        tmo_hit;
    logic        unused_rd;

    // only the STATUS done bit is consumed
    assign unused_rd = ^mgmt_readdata[31:1];
    assign tmo_hit   = (tcnt == TIMEOUT - 20'd1);

    // address/data of the write that follows the one now in flight
    always_comb begin
        wr_next  = IDLE;
        nxt_addr = 6'd0;
        nxt_data = 32'd0;
        case (state)
            W_MODE: begin wr_next = W_N;     nxt_addr = 6'd3; nxt_data = {14'b0, n_q};          end
            W_N:    begin wr_next = W_M;     nxt_addr = 6'd4; nxt_data = {14'b0, m_q};          end
            W_M:    begin wr_next = W_C0;    nxt_addr = 6'd5; nxt_data = {9'b0, 5'd0, c0_q};    end
            W_C0:   begin wr_next = W_K;     nxt_addr = 6'd7; nxt_data = k_q;                   end
            W_K:    begin wr_next = W_BW;    nxt_addr = 6'd8; nxt_data = {28'b0, bw_q};         end
            W_BW:   begin wr_next = W_CP;    nxt_addr = 6'd9; nxt_data = {29'b0, cp_q};         end
            W_CP:   begin wr_next = W_START; nxt_addr = 6'd2; nxt_data = 32'd1;                 end
            default: ;
        endcase
    end

    // sequencer with registered bus strobes and status outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            cfg_busy       <= 1'b0;
            cfg_done       <= 1'b0;
            cfg_error      <= 1'b0;
            mgmt_address   <= 6'd0;
            mgmt_write     <= 1'b0;
            mgmt_read      <= 1'b0;
            mgmt_writedata <= 32'd0;
            m_q            <= 18'd0;
            n_q            <= 18'd0;
            c0_q           <= 18'd0;
            k_q            <= 32'd0;
            bw_q           <= 4'd0;
            cp_q           <= 3'd0;
            tcnt           <= 20'd0;
            mask_cnt       <= 5'd0;
            poll_gap       <= 1'b0;
        end else begin
            cfg_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        m_q            <= cfg_m;
                        n_q            <= cfg_n;
                        c0_q           <= cfg_c0;
                        k_q            <= cfg_k;
                        bw_q           <= cfg_bw;
                        cp_q           <= cfg_cp;
                        cfg_busy       <= 1'b1;
                        cfg_error      <= 1'b0;
                        mgmt_write     <= 1'b1;
                        mgmt_address   <= 6'd0;
                        mgmt_writedata <= 32'd0;
                        state          <= W_MODE;
                    end
                end
                W_MODE, W_N, W_M, W_C0, W_K, W_BW, W_CP: begin
                    if (!mgmt_waitrequest) begin
                        state          <= wr_next;
                        mgmt_address   <= nxt_addr;
                        mgmt_writedata <= nxt_data;
                    end
                end
                W_START: begin
                    if (!mgmt_waitrequest) begin
                        mgmt_write     <= 1'b0;
                        mgmt_writedata <= 32'd0;
                        mgmt_read      <= 1'b1;
                        mgmt_address   <= 6'd1;
                        tcnt           <= 20'd0;
                        poll_gap       <= 1'b0;
                        state          <= POLL;
                    end
                end
                POLL: begin
                    if (tmo_hit) begin
                        state        <= ERR;
                        cfg_busy     <= 1'b0;
                        cfg_error    <= 1'b1;
                        mgmt_read    <= 1'b0;
                        mgmt_address <= 6'd0;
                    end else begin
                        tcnt <= tcnt + 20'd1;
                        if (poll_gap) begin
                            mgmt_read <= 1'b1;
                            poll_gap  <= 1'b0;
                        end else if (!mgmt_waitrequest) begin
                            mgmt_read <= 1'b0;
                            if (mgmt_readdata[0]) begin
                                mgmt_address <= 6'd0;
                                tcnt         <= 20'd0;
                                mask_cnt     <= 5'd16;
                                state        <= LOCK;
                            end else begin
                                poll_gap <= 1'b1;
                            end
                        end
                    end
                end
                LOCK: begin
                    if (tmo_hit) begin
                        state     <= ERR;
                        cfg_busy  <= 1'b0;
                        cfg_error <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 20'd1;
                        if (mask_cnt != 5'd0) begin
                            mask_cnt <= mask_cnt - 5'd1;
                        end else if (pll_locked) begin
                            cfg_done <= 1'b1;
                            cfg_busy <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                end
                ERR: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pll_hdmi_cfg_master.sv
// Directed bench for the HDMI PLL reconfig master. A negedge responder models
// the reconfig slave (optional 5-cycle stalls, scripted STATUS answers) and
// logs completed writes, reads and done pulses for the test tasks to inspect.
module tb_pll_hdmi_cfg_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_start = 1'b0;
    logic [17:0] cfg_m = '0, cfg_n = '0, cfg_c0 = '0;
    logic [31:0] cfg_k = '0;
    logic [3:0]  cfg_bw = '0;
    logic [2:0]  cfg_cp = '0;
    logic        cfg_busy, cfg_done, cfg_error;
    logic [5:0]  mgmt_address;
    logic        mgmt_write, mgmt_read;
    logic [31:0] mgmt_writedata;
    logic [31:0] mgmt_readdata = '0;
    logic        mgmt_waitrequest = 1'b0;
    logic        pll_locked = 1'b0;

    int total = 0;
    int bad = 0;

    bit          stall_mode = 0;
    int          status_zero = 0;
    int          stall_cnt = 0;
    int          wr_n = 0, rd_n = 0, done_n = 0, both_err = 0, unstable = 0;
    logic [5:0]  wr_a [0:31];
    logic [31:0] wr_d [0:31];
    bit          prev_pend = 0;
    logic        prev_w, prev_r;
    logic [5:0]  prev_a;
    logic [31:0] prev_d;

    logic [5:0]  exp_a [0:7] = '{6'd0, 6'd3, 6'd4, 6'd5, 6'd7, 6'd8, 6'd9, 6'd2};
    logic [31:0] exp_d [0:7] = '{32'h0, 32'h10000, 32'h404, 32'h20201,
                                 32'hE8F5C239, 32'h6, 32'h1, 32'h1};

    pll_hdmi_cfg_master #(.TIMEOUT(20'd64)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start),
        .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_c0(cfg_c0), .cfg_k(cfg_k),
        .cfg_bw(cfg_bw), .cfg_cp(cfg_cp),
        .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_error(cfg_error),
        .mgmt_address(mgmt_address), .mgmt_write(mgmt_write), .mgmt_read(mgmt_read),
        .mgmt_writedata(mgmt_writedata), .mgmt_readdata(mgmt_readdata),
        .mgmt_waitrequest(mgmt_waitrequest), .pll_locked(pll_locked)
    );

    always #5 clk = ~clk;

    // slave model and transaction logger
    always @(negedge clk) begin
        if (mgmt_write && mgmt_read) both_err++;
        if (prev_pend && (mgmt_write !== prev_w || mgmt_read !== prev_r ||
                          mgmt_address !== prev_a || mgmt_writedata !== prev_d))
            unstable++;
        if (mgmt_write || mgmt_read) begin
            if (stall_mode && stall_cnt < 5) begin
                mgmt_waitrequest = 1'b1;
                mgmt_readdata    = 32'h0;
                stall_cnt++;
            end else begin
                mgmt_waitrequest = 1'b0;
                stall_cnt = 0;
                if (mgmt_write) begin
                    if (wr_n < 32) begin
                        wr_a[wr_n] = mgmt_address;
                        wr_d[wr_n] = mgmt_writedata;
                    end
                    wr_n++;
                end else begin
                    mgmt_readdata = (rd_n < status_zero) ? 32'hFFFF_FFFE : 32'h0000_0001;
                    rd_n++;
                end
            end
        end else begin
            mgmt_waitrequest = 1'b0;
            stall_cnt = 0;
        end
        prev_pend = (mgmt_write || mgmt_read) && mgmt_waitrequest;
        prev_w = mgmt_write;
        prev_r = mgmt_read;
        prev_a = mgmt_address;
        prev_d = mgmt_writedata;
        if (cfg_done) done_n++;
    end

    task automatic clear_log();
        wr_n = 0; rd_n = 0; done_n = 0; both_err = 0; unstable = 0;
    endtask

    task automatic set_cfg();
        cfg_m  = {1'b0, 1'b0, 8'd4, 8'd4};
        cfg_n  = {1'b0, 1'b1, 8'd0, 8'd0};
        cfg_c0 = {1'b1, 1'b0, 8'd2, 8'd1};
        cfg_k  = 32'hE8F5C239;
        cfg_bw = 4'd6;
        cfg_cp = 3'd1;
    endtask

    // pulse cfg_start and wait for busy to fall; lat counts edges after the start edge
    task automatic run_seq(input int poke_at, input int lock_at, output int lat, output logic busy0);
        cfg_start = 1'b1;
        @(posedge clk); #2;
        cfg_start = 1'b0;
        busy0 = cfg_busy;
        lat = 0;
        while (cfg_busy && lat < 2000) begin
            @(posedge clk); #2;
            cfg_start = 1'b0;
            lat++;
            if (lat == poke_at) begin
                cfg_start = 1'b1;
                cfg_m = 18'h3FFFF;
                cfg_k = 32'h1234_5678;
            end
            if (lat == lock_at) pll_locked = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        total++; if (cfg_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", cfg_busy); end
        total++; if (cfg_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", cfg_done); end
        total++; if (cfg_error !== 1'b0) begin bad++; $display("FAIL reset_error got=%b want=0", cfg_error); end
        total++; if ({mgmt_write, mgmt_read} !== 2'b00) begin bad++; $display("FAIL reset_strobes got=%b want=00", {mgmt_write, mgmt_read}); end
        total++; if (mgmt_address !== 6'd0 || mgmt_writedata !== 32'd0) begin bad++;
            $display("FAIL reset_bus got addr=%0d data=%h want 0/0", mgmt_address, mgmt_writedata); end
        rst_n = 1'b1;
        @(posedge clk); #2;
    endtask

    task automatic test_zero_wait();
        int lat; logic busy0;
        clear_log(); set_cfg();
        stall_mode = 0; status_zero = 0; pll_locked = 1'b1;
        run_seq(-1, -1, lat, busy0);
        total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL zw_busy_rise got=%b want=1", busy0); end
        total++; if (cfg_done !== 1'b1) begin bad++; $display("FAIL zw_done_with_busy_fall got=%b want=1", cfg_done); end
        total++; if (lat != 26) begin bad++; $display("FAIL zw_latency got=%0d want=26", lat); end
        @(posedge clk); #2;
        total++; if (cfg_done !== 1'b0) begin bad++; $display("FAIL zw_done_width got=%b want=0", cfg_done); end
        total++; if (done_n != 1) begin bad++; $display("FAIL zw_done_count got=%0d want=1", done_n); end
        total++; if (wr_n != 8) begin bad++; $display("FAIL zw_write_count got=%0d want=8", wr_n); end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (wr_a[i] !== exp_a[i] || wr_d[i] !== exp_d[i]) begin bad++;
                $display("FAIL zw_write%0d got=(%0d,%h) want=(%0d,%h)", i, wr_a[i], wr_d[i], exp_a[i], exp_d[i]); end
        end
        total++; if (rd_n != 1) begin bad++; $display("FAIL zw_read_count got=%0d want=1", rd_n); end
        total++; if (both_err != 0) begin bad++; $display("FAIL zw_strobe_overlap got=%0d want=0", both_err); end
        total++; if (cfg_error !== 1'b0) begin bad++; $display("FAIL zw_error got=%b want=0", cfg_error); end
    endtask

    task automatic test_stalls();
        int lat; logic busy0;
        clear_log(); set_cfg();
        stall_mode = 1; status_zero = 0; pll_locked = 1'b1;
        run_seq(-1, -1, lat, busy0);
        total++; if (lat != 71) begin bad++; $display("FAIL st_latency got=%0d want=71", lat); end
        @(posedge clk); #2;
        stall_mode = 0;
        total++; if (unstable != 0) begin bad++; $display("FAIL st_bus_stable got=%0d changes want=0", unstable); end
        total++; if (wr_n != 8) begin bad++; $display("FAIL st_write_count got=%0d want=8", wr_n); end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (wr_a[i] !== exp_a[i] || wr_d[i] !== exp_d[i]) begin bad++;
                $display("FAIL st_write%0d got=(%0d,%h) want=(%0d,%h)", i, wr_a[i], wr_d[i], exp_a[i], exp_d[i]); end
        end
        total++; if (rd_n != 1) begin bad++; $display("FAIL st_read_count got=%0d want=1", rd_n); end
        total++; if (done_n != 1) begin bad++; $display("FAIL st_done_count got=%0d want=1", done_n); end
        total++; if (both_err != 0) begin bad++; $display("FAIL st_strobe_overlap got=%0d want=0", both_err); end
    endtask

    task automatic test_polling();
        int lat; logic busy0;
        clear_log(); set_cfg();
        stall_mode = 0; status_zero = 3; pll_locked = 1'b1;
        run_seq(-1, -1, lat, busy0);
        total++; if (lat != 32) begin bad++; $display("FAIL poll_latency got=%0d want=32", lat); end
        @(posedge clk); #2;
        total++; if (rd_n != 4) begin bad++; $display("FAIL poll_read_count got=%0d want=4", rd_n); end
        total++; if (done_n != 1) begin bad++; $display("FAIL poll_done_count got=%0d want=1", done_n); end
    endtask

    task automatic test_timeout();
        int lat; logic busy0;
        clear_log(); set_cfg();
        stall_mode = 0; status_zero = 100000; pll_locked = 1'b1;
        run_seq(-1, -1, lat, busy0);
        total++; if (cfg_error !== 1'b1) begin bad++; $display("FAIL tmo_error got=%b want=1", cfg_error); end
        total++; if (lat >= 2000) begin bad++; $display("FAIL tmo_busy_fall got lat=%0d want <2000", lat); end
        repeat (3) @(posedge clk); #2;
        total++; if (done_n != 0) begin bad++; $display("FAIL tmo_no_done got=%0d want=0", done_n); end
        total++; if (cfg_error !== 1'b1) begin bad++; $display("FAIL tmo_sticky got=%b want=1", cfg_error); end
        clear_log(); status_zero = 0;
        run_seq(-1, -1, lat, busy0);
        total++; if (lat != 26) begin bad++; $display("FAIL tmo_rerun_latency got=%0d want=26", lat); end
        total++; if (cfg_error !== 1'b0) begin bad++; $display("FAIL tmo_error_cleared got=%b want=0", cfg_error); end
        @(posedge clk); #2;
    endtask

    task automatic test_start_ignored();
        int lat; logic busy0;
        clear_log(); set_cfg();
        stall_mode = 0; status_zero = 0; pll_locked = 1'b1;
        run_seq(4, -1, lat, busy0);
        total++; if (lat != 26) begin bad++; $display("FAIL ign_latency got=%0d want=26", lat); end
        @(posedge clk); #2;
        set_cfg();
        total++; if (wr_n != 8) begin bad++; $display("FAIL ign_write_count got=%0d want=8", wr_n); end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (wr_a[i] !== exp_a[i] || wr_d[i] !== exp_d[i]) begin bad++;
                $display("FAIL ign_write%0d got=(%0d,%h) want=(%0d,%h)", i, wr_a[i], wr_d[i], exp_a[i], exp_d[i]); end
        end
        total++; if (done_n != 1) begin bad++; $display("FAIL ign_done_count got=%0d want=1", done_n); end
        total++; if (cfg_busy !== 1'b0) begin bad++; $display("FAIL ign_no_restart got busy=%b want=0", cfg_busy); end
    endtask

    task automatic test_lock_wait();
        int lat; logic busy0;
        clear_log(); set_cfg();
        stall_mode = 0; status_zero = 0; pll_locked = 1'b0;
        run_seq(-1, 40, lat, busy0);
        total++; if (lat != 41) begin bad++; $display("FAIL lock_latency got=%0d want=41", lat); end
        @(posedge clk); #2;
        total++; if (done_n != 1) begin bad++; $display("FAIL lock_done_count got=%0d want=1", done_n); end
    endtask

    task automatic test_reset_mid();
        int seen;
        clear_log(); set_cfg();
        stall_mode = 0; status_zero = 0; pll_locked = 1'b1;
        cfg_start = 1'b1;
        @(posedge clk); #2;
        cfg_start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        total++; if (mgmt_address !== 6'd4 || mgmt_write !== 1'b1) begin bad++;
            $display("FAIL rst_mid_in_wm got addr=%0d wr=%b want 4/1", mgmt_address, mgmt_write); end
        rst_n = 1'b0;
        @(posedge clk); #2;
        total++; if ({mgmt_write, mgmt_read} !== 2'b00) begin bad++; $display("FAIL rst_mid_strobes got=%b want=00", {mgmt_write, mgmt_read}); end
        total++; if (cfg_busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b want=0", cfg_busy); end
        rst_n = 1'b1;
        @(posedge clk); #2;
        seen = wr_n;
        repeat (10) @(posedge clk);
        #2;
        total++; if (wr_n != seen) begin bad++; $display("FAIL rst_mid_idle got writes=%0d want=%0d", wr_n, seen); end
        total++; if (cfg_busy !== 1'b0) begin bad++; $display("FAIL rst_mid_stays_idle got busy=%b want=0", cfg_busy); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_stalls();
        test_polling();
        test_timeout();
        test_start_ignored();
        test_lock_wait();
        test_reset_mid();
        test_zero_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
